im_loader: RTL and testbench

//   Writer side of the 13-bit instruction-memory interface. Receives a program as
//   a byte stream (valid/ready), packs byte pairs into {opcode[4:0], operand[7:0]}

---
 rtl/im_loader.sv | 157 +++++++++++++++
 tb/tb_im_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Instruction-memory loader: unpacks a COUNT/HI/LO byte stream into 13-bit words and
// writes them, holding the CPU in reset until a clean load. Define IM_LOADER_CHECKSUM_EN for a trailing checksum byte.
module im_loader #(
    parameter int AW = 8,
    parameter int DW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

`ifdef IM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_WR, S_CSUM, S_DONE, S_FAIL} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_WR, S_DONE, S_FAIL} state_t;
`endif

    state_t          r_state, w_next;
    logic [AW:0]     r_remaining;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;
    logic [4:0]      r_hi;
    logic            w_xfer;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]      r_sum;
    logic [7:0]      w_sum_final;
    assign w_sum_final = r_sum + rx_data;
`endif

    assign w_xfer = rx_valid & rx_ready;
    assign waddr  = r_waddr;
    assign wdata  = r_wdata;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        we       = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_rst  = 1'b1;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                done    = (r_state == S_DONE);
                err     = (r_state == S_FAIL);
                cpu_rst = (r_state != S_DONE);
                if (start) w_next = S_COUNT;
            end
            S_COUNT: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) w_next = S_HI;
            end
            S_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                // Opcodes are 5 bits; any upper bit set means a corrupt stream.
                if (w_xfer) w_next = (rx_data[7:5] != 3'b000) ? S_FAIL : S_LO;
            end
            S_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) w_next = S_WR;
            end
            S_WR: begin
                we   = 1'b1;
                busy = 1'b1;
                if (r_remaining == (AW+1)'(1)) begin
`ifdef IM_LOADER_CHECKSUM_EN
                    w_next = S_CSUM;
`else
                    w_next = S_DONE;
`endif
                end else begin
                    w_next = S_HI;
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) w_next = (w_sum_final == 8'h00) ? S_DONE : S_FAIL;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_hi        <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        r_waddr <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                S_COUNT: begin
                    if (w_xfer) begin
                        // A count of zero means a full memory image.
                        r_remaining <= (rx_data == 8'h00) ? (AW+1)'(1 << AW) : (AW+1)'(rx_data);
`ifdef IM_LOADER_CHECKSUM_EN
                        r_sum <= r_sum + rx_data;
`endif
                    end
                end
                S_HI: begin
                    if (w_xfer) begin
                        r_hi <= rx_data[4:0];
`ifdef IM_LOADER_CHECKSUM_EN
                        r_sum <= r_sum + rx_data;
`endif
                    end
                end
                S_LO: begin
                    if (w_xfer) begin
                        r_wdata <= DW'({r_hi, rx_data});
`ifdef IM_LOADER_CHECKSUM_EN
                        r_sum <= r_sum + rx_data;
`endif
                    end
                end
                S_WR: begin
                    r_waddr     <= r_waddr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: writes are captured by a monitor and compared
// against hand-computed addresses/words; follows IM_LOADER_CHECKSUM_EN if defined.
module tb_im_loader;
    localparam int AW = 8;
    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          rst, start, rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready, we, cpu_rst, busy, done, err;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    im_loader #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle
    int            we_cnt   = 0;
    int            rdy_viol = 0;
    logic [AW-1:0] m_addr [0:511];
    logic [DW-1:0] m_data [0:511];

    always @(negedge clk) begin
        if (we) begin
            if (we_cnt < 512) begin
                m_addr[we_cnt] = waddr;
                m_data[we_cnt] = wdata;
            end
            we_cnt++;
            if (rx_ready) rdy_viol++;
        end
    end

    logic [7:0] csum;

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        csum = 8'h00;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        chk("byte_accepted", 32'(ok), 32'd1);
        csum = csum + b;
    endtask

    task automatic send_csum(input logic [7:0] adj);
`ifdef IM_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = 8'h00 - csum + adj;
        send(c, 0);
`else
        if (adj != 8'h00) rx_valid = 1'b0;
`endif
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done || err) seen = 1'b1;
        end
        chk("load_finished", 32'(seen), 32'd1);
    endtask

    task automatic load3(input bit rnd, input string tg);
        int base;
        int g;
        logic [7:0] bytes [0:6];
        bytes = '{8'h03, 8'h08, 8'h00, 8'h10, 8'h03, 8'h0F, 8'h02};
        base = we_cnt;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            g = rnd ? int'($urandom_range(0, 3)) : 0;
            send(bytes[i], g);
        end
        send_csum(8'h00);
        wait_end();
        chk({tg, "_we_count"}, 32'(we_cnt - base), 32'd3);
        chk({tg, "_addr0"}, 32'(m_addr[base]),   32'h0);
        chk({tg, "_data0"}, 32'(m_data[base]),   32'h0800);
        chk({tg, "_addr1"}, 32'(m_addr[base+1]), 32'h1);
        chk({tg, "_data1"}, 32'(m_data[base+1]), 32'h1003);
        chk({tg, "_addr2"}, 32'(m_addr[base+2]), 32'h2);
        chk({tg, "_data2"}, 32'(m_data[base+2]), 32'h0F02);
        chk({tg, "_done"},     32'(done),     32'd1);
        chk({tg, "_err"},      32'(err),      32'd0);
        chk({tg, "_cpu_rst"},  32'(cpu_rst),  32'd0);
        chk({tg, "_busy"},     32'(busy),     32'd0);
        chk({tg, "_rx_ready"}, 32'(rx_ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        csum = 8'h00;
        do_reset();

        // Reset values
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_we",       32'(we),       32'd0);
        chk("rst_waddr",    32'(waddr),    32'd0);
        chk("rst_wdata",    32'(wdata),    32'd0);
        chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);

        // 1: back-to-back stream, 2: stalled stream
        load3(1'b0, "t1");
        load3(1'b1, "t2");
        chk("t2_rx_ready_in_wr", 32'(rdy_viol), 32'd0);

        // 3: bad opcode byte aborts without a write, then a clean load recovers
        base = we_cnt;
        pulse_start();
        send(8'h02, 0);
        send(8'h28, 0);
        wait_end();
        chk("t3_err",      32'(err),            32'd1);
        chk("t3_done",     32'(done),           32'd0);
        chk("t3_cpu_rst",  32'(cpu_rst),        32'd1);
        chk("t3_busy",     32'(busy),           32'd0);
        chk("t3_no_write", 32'(we_cnt - base),  32'd0);
        pulse_start();
        chk("t3_err_cleared", 32'(err),  32'd0);
        chk("t3_busy_set",    32'(busy), 32'd1);
        send(8'h01, 0);
        send(8'h01, 0);
        send(8'hFF, 0);
        send_csum(8'h00);
        wait_end();
        chk("t3_we_count", 32'(we_cnt - base), 32'd1);
        chk("t3_addr",     32'(m_addr[base]),  32'h0);
        chk("t3_data",     32'(m_data[base]),  32'h01FF);
        chk("t3_done2",    32'(done),          32'd1);

        // 4: count 0 loads the full 256-word image
        base = we_cnt;
        pulse_start();
        send(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            send(8'(i) & 8'h1F, 0);
            send(8'(i), 0);
        end
        send_csum(8'h00);
        wait_end();
        chk("t4_we_count", 32'(we_cnt - base), 32'd256);
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("t4_addr%0d", i), 32'(m_addr[base+i]), 32'(i));
            chk($sformatf("t4_data%0d", i), 32'(m_data[base+i]), 32'(((i & 32'h1F) << 8) | i));
        end
        chk("t4_done",       32'(done),  32'd1);
        chk("t4_waddr_wrap", 32'(waddr), 32'd0);

        // 5: reset in the middle of a load
        base = we_cnt;
        pulse_start();
        send(8'h04, 0);
        send(8'h08, 0);
        send(8'h00, 0);
        send(8'h10, 0);
        send(8'h03, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_we_count", 32'(we_cnt - base), 32'd2);
        chk("t5_we",       32'(we),       32'd0);
        chk("t5_busy",     32'(busy),     32'd0);
        chk("t5_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("t5_rx_ready", 32'(rx_ready), 32'd0);
        chk("t5_waddr",    32'(waddr),    32'd0);
        chk("t5_wdata",    32'(wdata),    32'd0);
        chk("t5_done",     32'(done),     32'd0);
        rst = 1'b0;
        base = we_cnt;
        pulse_start();
        send(8'h01, 0);
        send(8'h01, 0);
        send(8'hFF, 0);
        send_csum(8'h00);
        wait_end();
        chk("t5_restart_addr", 32'(m_addr[base]), 32'h0);
        chk("t5_restart_data", 32'(m_data[base]), 32'h01FF);
        chk("t5_restart_done", 32'(done),         32'd1);

        // 6: checksum byte (N + HI + LO + C == 0 mod 256) or plain short load
        base = we_cnt;
        pulse_start();
        send(8'h01, 0);
        send(8'h08, 0);
        send(8'h00, 0);
`ifdef IM_LOADER_CHECKSUM_EN
        send(8'hF7, 0);
        wait_end();
        chk("t6_good_done",    32'(done),          32'd1);
        chk("t6_good_cpu_rst", 32'(cpu_rst),       32'd0);
        chk("t6_good_data",    32'(m_data[base]),  32'h0800);
        base = we_cnt;
        pulse_start();
        send(8'h01, 0);
        send(8'h08, 0);
        send(8'h00, 0);
        send(8'hF8, 0);
        wait_end();
        chk("t6_bad_err",      32'(err),           32'd1);
        chk("t6_bad_cpu_rst",  32'(cpu_rst),       32'd1);
        chk("t6_bad_written",  32'(we_cnt - base), 32'd1);
`else
        wait_end();
        chk("t6_done",    32'(done),         32'd1);
        chk("t6_cpu_rst", 32'(cpu_rst),      32'd0);
        chk("t6_data",    32'(m_data[base]), 32'h0800);
        chk("t6_addr",    32'(m_addr[base]), 32'h0);
`endif

        // start while busy is ignored: load continues from where it was
        base = we_cnt;
        pulse_start();
        send(8'h02, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        send(8'h04, 0);
        send_csum(8'h00);
        wait_end();
        chk("busy_start_count", 32'(we_cnt - base), 32'd2);
        chk("busy_start_addr1", 32'(m_addr[base+1]), 32'h1);
        chk("busy_start_data1", 32'(m_data[base+1]), 32'h0304);
        chk("busy_start_done",  32'(done),           32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
